// File: rtl/branch_sequencer.sv
// branch_sequencer: KGP-RISC multi-cycle PC sequencer (FETCH/DECODE/EXEC/RESOLVE) with branch resolution.
// Optional branch statistics counters enabled by `BRANCH_STATS_EN.
module branch_sequencer #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              imem_valid,
  input  logic              halt_req,
  input  logic [3:0]        branch_op,
  input  logic [ADDR_W-1:0] label,
  input  logic [31:0]       rs_value,
  input  logic [31:0]       result,
  input  logic              carry,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic              ir_load,
  output logic              exec_en,
  output logic              wb_en,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic              branch_taken,
  output logic              fault,
  output logic [2:0]        state,
  output logic [15:0]       br_count,
  output logic [15:0]       taken_count
);
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, RESOLVE = 3'd4, HALT = 3'd5} state_t;
  localparam logic [3:0] TMO_LAST = 4'(FETCH_TIMEOUT - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, link_q, link_d, pc_inc, target;
  logic [3:0] cnt_q, cnt_d;
  logic fault_q, fault_d, cond, is_br;
  logic unused_result;
  assign unused_result = ^result[30:0];
  assign pc_inc = pc_q + ADDR_W'(4);
  assign target = (branch_op == 4'd2 ? rs_value[ADDR_W-1:0] : label) & ~ADDR_W'(3);
  assign is_br = (branch_op != 4'd0) && (branch_op <= 4'd8);
  always_comb begin
    cond = 1'b0;
    case (branch_op)
      4'd1, 4'd2, 4'd6: cond = 1'b1;
      4'd3: cond = result[31];
      4'd4: cond = zero;
      4'd5: cond = !zero;
      4'd7: cond = carry;
      4'd8: cond = !carry;
      default: cond = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    link_d = link_q;
    cnt_d = '0;
    fault_d = fault_q;
    imem_req = 1'b0;
    ir_load = 1'b0;
    exec_en = 1'b0;
    wb_en = 1'b0;
    link_we = 1'b0;
    branch_taken = 1'b0;
    case (state_q)
      IDLE: state_d = run ? FETCH : IDLE;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DECODE: state_d = halt_req ? HALT : EXEC;
      EXEC: begin
        exec_en = 1'b1;
        state_d = RESOLVE;
      end
      RESOLVE: begin
        branch_taken = cond;
        wb_en = !is_br;
        link_we = branch_op == 4'd6;
        pc_d = cond ? target : pc_inc;
        link_d = link_we ? pc_inc : link_q;
        state_d = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      link_q <= '0;
      cnt_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      link_q <= link_d;
      cnt_q <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign pc = pc_q;
  assign link_addr = link_q;
  assign fault = fault_q;
  assign state = state_q;
`ifdef BRANCH_STATS_EN
  logic [15:0] br_q, br_d, tk_q, tk_d;
  assign br_d = (state_q == RESOLVE && is_br && br_q != 16'hFFFF) ? br_q + 16'd1 : br_q;
  assign tk_d = (branch_taken && tk_q != 16'hFFFF) ? tk_q + 16'd1 : tk_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      br_q <= '0;
      tk_q <= '0;
    end else begin
      br_q <= br_d;
      tk_q <= tk_d;
    end
  end
  assign br_count = br_q;
  assign taken_count = tk_q;
`else
  assign br_count = '0;
  assign taken_count = '0;
`endif
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed instruction-level model of branch_sequencer, checked on every cycle.
module tb_branch_sequencer;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3, S_RESOLVE = 3'd4, S_HALT = 3'd5;
  logic clk = 1'b0;
  logic reset = 1'b1, run = 1'b0, imem_valid = 1'b0, halt_req = 1'b0, carry = 1'b0, zero = 1'b0;
  logic [3:0] branch_op = '0;
  logic [31:0] label = '0, rs_value = '0, result = '0;
  logic [31:0] pc, link_addr;
  logic imem_req, ir_load, exec_en, wb_en, link_we, branch_taken, fault;
  logic [2:0] state;
  logic [15:0] br_count, taken_count;
  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;
  logic [2:0] exp_state;
  logic [31:0] exp_pc, exp_link;
  logic exp_fault;
  logic [15:0] exp_br, exp_tk;
  logic e_res, e_tk;

  branch_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .imem_valid(imem_valid), .halt_req(halt_req),
    .branch_op(branch_op), .label(label), .rs_value(rs_value), .result(result),
    .carry(carry), .zero(zero), .pc(pc), .imem_req(imem_req), .ir_load(ir_load),
    .exec_en(exec_en), .wb_en(wb_en), .link_we(link_we), .link_addr(link_addr),
    .branch_taken(branch_taken), .fault(fault), .state(state),
    .br_count(br_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_taken(input logic [3:0] op, input logic [31:0] res, input bit cy, input bit z);
    case (op)
      4'd1, 4'd2, 4'd6: return 1'b1;
      4'd3: return res[31];
      4'd4: return z;
      4'd5: return !z;
      4'd7: return cy;
      4'd8: return !cy;
      default: return 1'b0;
    endcase
  endfunction

  // Per-cycle check of the DUT against the expected architectural state and phase.
  always @(negedge clk) begin
    if (chk_en) begin
      e_res = exp_state == S_RESOLVE;
      e_tk = e_res && m_taken(branch_op, result, carry, zero);
      chk("state", {29'd0, state}, {29'd0, exp_state});
      chk("pc", pc, exp_pc);
      chk("fault", {31'd0, fault}, {31'd0, exp_fault});
      chk("link_addr", link_addr, exp_link);
      chk("imem_req", {31'd0, imem_req}, {31'd0, exp_state == S_FETCH});
      chk("ir_load", {31'd0, ir_load}, {31'd0, exp_state == S_FETCH && imem_valid});
      chk("exec_en", {31'd0, exec_en}, {31'd0, exp_state == S_EXEC});
      chk("wb_en", {31'd0, wb_en}, {31'd0, e_res && (branch_op == 4'd0 || branch_op > 4'd8)});
      chk("link_we", {31'd0, link_we}, {31'd0, e_res && branch_op == 4'd6});
      chk("branch_taken", {31'd0, branch_taken}, {31'd0, e_tk});
`ifdef BRANCH_STATS_EN
      chk("br_count", {16'd0, br_count}, {16'd0, exp_br});
      chk("taken_count", {16'd0, taken_count}, {16'd0, exp_tk});
`else
      chk("br_count", {16'd0, br_count}, 32'd0);
      chk("taken_count", {16'd0, taken_count}, 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    run = 1'b0;
    imem_valid = 1'b0;
    halt_req = 1'b0;
    branch_op = '0;
    repeat (n) begin
      tick();
      exp_state = S_IDLE;
      exp_pc = 32'h0;
      exp_link = 32'h0;
      exp_fault = 1'b0;
      exp_br = '0;
      exp_tk = '0;
      chk_en = 1'b1;
    end
    reset = 1'b0;
  endtask

  task automatic start();
    run = 1'b1;
    tick();
    exp_state = S_FETCH;
    run = 1'b0;
  endtask

  // One whole instruction from FETCH, with wt idle fetch cycles before imem_valid.
  task automatic instr(input logic [3:0] op, input logic [31:0] lbl, input logic [31:0] rs,
                       input logic [31:0] res, input bit cy, input bit z, input bit hlt, input int wt);
    bit tk;
    branch_op = op;
    label = lbl;
    rs_value = rs;
    result = res;
    carry = cy;
    zero = z;
    halt_req = hlt;
    imem_valid = 1'b0;
    repeat (wt) tick();
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    exp_state = S_DECODE;
    tick();
    halt_req = 1'b0;
    if (hlt) begin
      exp_state = S_HALT;
      return;
    end
    exp_state = S_EXEC;
    tick();
    exp_state = S_RESOLVE;
    tick();
    tk = m_taken(op, res, cy, z);
    if (op == 4'd6) exp_link = exp_pc + 32'd4;
    if (op >= 4'd1 && op <= 4'd8 && exp_br != 16'hFFFF) exp_br = exp_br + 16'd1;
    if (tk && exp_tk != 16'hFFFF) exp_tk = exp_tk + 16'd1;
    exp_pc = tk ? ((op == 4'd2 ? rs : lbl) & ~32'h3) : exp_pc + 32'd4;
    exp_state = S_FETCH;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(2);
    chk("lit_reset_state", {29'd0, state}, 32'd0);
    chk("lit_reset_pc", pc, 32'h0);
    start();
    instr(4'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("lit_none_pc", pc, 32'h4);
    instr(4'd1, 32'h10, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("lit_b_pc", pc, 32'h10);
    instr(4'd4, 32'h40, 32'h0, 32'h0, 0, 1, 0, 2);
    chk("lit_bz_taken", pc, 32'h40);
    instr(4'd4, 32'h80, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("lit_bz_not", pc, 32'h44);
    instr(4'd3, 32'h20, 32'h0, 32'h8000_0000, 0, 0, 0, 1);
    chk("lit_bltz", pc, 32'h20);
    instr(4'd6, 32'h100, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("lit_bl_pc", pc, 32'h100);
    chk("lit_bl_link", link_addr, 32'h24);
    instr(4'd2, 32'h0, 32'h1237, 32'h0, 0, 0, 0, 0);
    chk("lit_br_pc", pc, 32'h1234);
    instr(4'd5, 32'h300, 32'h0, 32'h0, 0, 0, 0, 0);
    instr(4'd7, 32'h400, 32'h0, 32'h0, 1, 0, 0, 0);
    instr(4'd8, 32'h500, 32'h0, 32'h0, 1, 0, 0, 0);
    instr(4'd12, 32'h600, 32'h0, 32'h0, 1, 1, 0, 0);
    instr(4'd5, 32'h700, 32'h0, 32'h0, 0, 1, 0, 0);
    instr(4'd3, 32'h800, 32'h0, 32'h7FFF_FFFF, 0, 0, 0, 14);
    instr(4'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 14);
    chk("lit_wait14_pc", pc, 32'h414);
    imem_valid = 1'b0;
    repeat (14) tick();
    tick();
    exp_state = S_HALT;
    exp_fault = 1'b1;
    run = 1'b1;
    imem_valid = 1'b1;
    repeat (3) tick();
    run = 1'b0;
    imem_valid = 1'b0;
    chk("lit_tmo_fault", {31'd0, fault}, 32'd1);
    chk("lit_tmo_pc", pc, 32'h414);
    chk("lit_tmo_state", {29'd0, state}, 32'd5);
    do_reset(1);
    chk("lit_rst_fault", {31'd0, fault}, 32'd0);
    chk("lit_rst_pc", pc, 32'h0);
    start();
    instr(4'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("lit_align_pc", pc, 32'hFFFF_FFFC);
    instr(4'd9, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("lit_wrap_pc", pc, 32'h0);
    instr(4'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    instr(4'd1, 32'h50, 32'h0, 32'h0, 0, 0, 1, 0);
    run = 1'b1;
    repeat (2) tick();
    run = 1'b0;
    chk("lit_halt_state", {29'd0, state}, 32'd5);
    chk("lit_halt_pc", pc, 32'h4);
    do_reset(1);
    start();
    instr(4'd1, 32'h80, 32'h0, 32'h0, 0, 0, 0, 0);
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    exp_state = S_DECODE;
    tick();
    exp_state = S_EXEC;
    do_reset(1);
    chk("lit_abort_state", {29'd0, state}, 32'd0);
    chk("lit_abort_pc", pc, 32'h0);
    chk("lit_abort_exec", {31'd0, exec_en}, 32'd0);
    start();
    instr(4'd1, 32'h10, 32'h0, 32'h0, 0, 0, 0, 0);
    instr(4'd4, 32'h90, 32'h0, 32'h0, 0, 0, 0, 0);
    instr(4'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0);
    instr(4'd6, 32'h40, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("lit_stats_pc", pc, 32'h40);
    chk("lit_stats_link", link_addr, 32'h1C);
`ifdef BRANCH_STATS_EN
    chk("lit_br_count", {16'd0, br_count}, 32'd3);
    chk("lit_taken_count", {16'd0, taken_count}, 32'd2);
`endif
    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
